// File: rtl/riscv_dmem_rsp.sv
// Scratchpad data-memory responder. Terminates the write-buffer memory
// request interface: one request accepted per ready cycle, byte-lane writes,
// full-word lane-aligned reads, and exactly one ack or err per accepted
// request after WAIT wait states.
module riscv_dmem_rsp #(
    parameter int              XLEN  = 32,
    parameter int              DEPTH = 1024,
    parameter logic [XLEN-1:0] BASE  = '0,
    parameter int              WAIT  = 0
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            mem_req_i,
    input  logic [XLEN-1:0] mem_adr_i,
    input  logic [2:0]      mem_size_i,
    input  logic [2:0]      mem_type_i,
    input  logic            mem_lock_i,
    input  logic [2:0]      mem_prot_i,
    input  logic            mem_we_i,
    input  logic [XLEN-1:0] mem_d_i,
    input  logic            cacheflush_i,
    output logic [XLEN-1:0] mem_q_o,
    output logic            mem_ack_o,
    output logic            mem_err_o,
    output logic [1:0]      dbg_state
);

    localparam int NB = XLEN / 8;
    localparam int LW = $clog2(NB);
    localparam int AW = $clog2(DEPTH);

    localparam logic [2:0] SZ_BYTE  = 3'b000;
    localparam logic [2:0] SZ_HWORD = 3'b001;
    localparam logic [2:0] SZ_WORD  = 3'b010;
    localparam logic [2:0] SZ_DWORD = 3'b011;
    localparam logic [2:0] TY_SINGLE = 3'b000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic [2:0] cnt;
    logic       err_q;

    logic [XLEN-1:0] mem [DEPTH];

    logic            ready;
    logic            accept;
    logic [XLEN-1:0] off;
    logic [AW-1:0]   widx;
    logic [LW-1:0]   lane;
    logic            misalign;
    logic            out_of_range;
    logic            req_err;
    logic [NB-1:0]   be;
    logic            wr_en;
    logic            rd_en;

    // Lock and protection attributes are accepted but carry no behaviour here.
    logic unused_attr;
    assign unused_attr = ^{mem_lock_i, mem_prot_i};

    // Handshake: mem_req_i is a valid qualifier; the responder is ready in IDLE
    // and in the response cycle. A request transfers on a rising edge where
    // mem_req_i & ready; all request fields are sampled only on that edge and a
    // request held while BUSY is simply ignored until ready returns.
    assign ready  = (state == IDLE) || (state == RESP);
    assign accept = mem_req_i && ready && rst_ni;

    // Offset from BASE; unsigned wrap below BASE lands out of range.
    assign off          = mem_adr_i - BASE;
    assign widx         = off[LW +: AW];
    assign lane         = off[LW-1:0];
    assign out_of_range = |off[XLEN-1:LW+AW];

    // Alignment check and lane enables decoded from size and low address bits.
    always_comb begin
        misalign = 1'b0;
        be       = '0;
        case (mem_size_i)
            SZ_BYTE: begin
                be = NB'(1'b1) << lane;
            end
            SZ_HWORD: begin
                misalign = off[0];
                be       = NB'(2'b11) << lane;
            end
            SZ_WORD: begin
                misalign = |off[1:0];
                be       = NB'(4'hF) << lane;
            end
            SZ_DWORD: begin
                misalign = (XLEN == 32) || (|off[2:0]);
                be       = '1;
            end
            default: begin
                misalign = 1'b1;
            end
        endcase
    end

    // A flush marker never errors and never touches the array.
    assign req_err = !cacheflush_i &&
                     ((mem_type_i != TY_SINGLE) || misalign || out_of_range);
    assign wr_en   = accept && mem_we_i  && !cacheflush_i && !req_err;
    assign rd_en   = accept && !mem_we_i && !cacheflush_i && !req_err;

    // State register, wait-state counter and captured error flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
            cnt   <= 3'd0;
            err_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                cnt   <= 3'(WAIT);
                err_q <= req_err;
            end else if (state == BUSY) begin
                cnt <= cnt - 3'd1;
            end
        end
    end

    // Next-state decode: wait states are counted down in BUSY.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) state_nxt = (WAIT == 0) ? RESP : BUSY;
            end
            BUSY: begin
                if (cnt == 3'd1) state_nxt = RESP;
            end
            RESP: begin
                if (accept) state_nxt = (WAIT == 0) ? RESP : BUSY;
                else        state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Lane-masked write commit on the acceptance edge; array is never reset.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            for (int i = 0; i < NB; i++) begin
                if (be[i]) mem[widx][8*i +: 8] <= mem_d_i[8*i +: 8];
            end
        end
    end

    // Read data register: full word, lanes left in place, updated only on reads.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q_o <= '0;
        end else if (rd_en) begin
            mem_q_o <= mem[widx];
        end
    end

    assign mem_ack_o = (state == RESP) && !err_q;
    assign mem_err_o = (state == RESP) &&  err_q;
    assign dbg_state = state;

endmodule
